polylut_elastic_pipe: RTL and testbench

POLYLUT_ELASTIC_PIPE -- requirements
Module: polylut_elastic_pipe

---
 rtl/polylut_elastic_pipe_if.sv | 21 ++
 rtl/polylut_elastic_pipe.sv | 102 ++++++++++
 tb/tb_polylut_elastic_pipe.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/polylut_elastic_pipe_if.sv
// Upstream/downstream handshake bundle for the elastic PolyLUT register pipe.
interface polylut_elastic_pipe_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/polylut_elastic_pipe.sv
// Bubble-collapsing elastic register pipe: each stage feeds external combinational
// logic through tap_q and loads the result back from tap_d into the next slice.
module polylut_elastic_pipe #(
    parameter int DATA_W = 64,
    parameter int STAGES = 6,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    polylut_elastic_pipe_if.slave          bus,
    output logic [(STAGES-1)*DATA_W-1:0]   tap_q,
    input  logic [(STAGES-1)*DATA_W-1:0]   tap_d,
    input  logic                           flush,
    output logic [$clog2(STAGES+1)-1:0]    occupancy,
    output logic [CNT_W-1:0]               stall_cnt
);
    localparam int OCC_W = $clog2(STAGES+1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] en;
    logic [DATA_W-1:0] data_q [STAGES];
    logic [DATA_W-1:0] data_d [STAGES];
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              accept;
    logic              run;

    // A stage may advance if it, or any stage downstream of it, is empty, or the sink takes.
    always_comb begin
        run = bus.out_ready;
        en  = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            run   = run | ~v_q[k];
            en[k] = run;
        end
    end

    assign bus.in_ready = en[0] & ~flush;
    assign accept       = bus.in_valid & en[0] & ~flush;

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (en[0]) begin
            v_d[0] = accept;
        end
        if (accept) begin
            data_d[0] = bus.in_data;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (en[k]) begin
                v_d[k] = v_q[k-1];
            end
            // Data only moves behind a valid item, so stale contents stay put under bubbles.
            if (en[k] && v_q[k-1] && !flush) begin
                data_d[k] = tap_d[(k-1)*DATA_W +: DATA_W];
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (v_q[STAGES-1] && !bus.out_ready && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(v_q[k]);
        end
    end

    always_comb begin
        tap_q = '0;
        for (int k = 0; k < STAGES-1; k++) begin
            tap_q[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign bus.out_data  = data_q[STAGES-1];
    assign bus.out_valid = v_q[STAGES-1];
    assign stall_cnt     = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            stall_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            stall_q <= stall_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_polylut_elastic_pipe.sv
// Scoreboard bench for polylut_elastic_pipe: STAGES=6, CNT_W=4, tap logic identity or +1.
module tb_polylut_elastic_pipe;
    localparam int DW     = 64;
    localparam int STAGES = 6;
    localparam int CNT_W  = 4;
    localparam int OCC_W  = $clog2(STAGES+1);

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } item_t;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       flush = 1'b0;
    logic [(STAGES-1)*DW-1:0]   tap_q;
    logic [(STAGES-1)*DW-1:0]   tap_d;
    logic [OCC_W-1:0]           occupancy;
    logic [CNT_W-1:0]           stall_cnt;
    logic                       tap_mode = 1'b0;

    item_t sb [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    exp_stall = 0;
    int    emitted = 0;
    bit    exact = 1'b0;
    bit    last_acc = 1'b0;

    polylut_elastic_pipe_if #(.DATA_W(DW)) bus ();

    polylut_elastic_pipe #(.DATA_W(DW), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .tap_q(tap_q), .tap_d(tap_d),
        .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        tap_d = '0;
        for (int k = 0; k < STAGES-1; k++) begin
            tap_d[k*DW +: DW] = tap_q[k*DW +: DW] + (tap_mode ? 64'd1 : 64'd0);
        end
    end

    // One cycle: called at a negedge with inputs set; checks, updates the model, crosses the edge.
    task automatic step();
        item_t e;
        bit    exp_rdy;
        #1;
        checks++;
        if (int'(occupancy) !== sb.size()) begin
            errors++; $display("FAIL occupancy got %0d expected %0d (cycle %0d)", occupancy, sb.size(), cyc);
        end
        exp_rdy = !flush && (sb.size() < STAGES || bus.out_ready);
        checks++;
        if (bus.in_ready !== exp_rdy) begin
            errors++; $display("FAIL in_ready got %b expected %b (cycle %0d)", bus.in_ready, exp_rdy, cyc);
        end
        checks++;
        if (int'(stall_cnt) !== exp_stall) begin
            errors++; $display("FAIL stall_cnt got %0d expected %0d (cycle %0d)", stall_cnt, exp_stall, cyc);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            emitted++;
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL unexpected_emit got %h expected no item", bus.out_data);
            end else begin
                e = sb.pop_front();
                if (bus.out_data !== e.data) begin
                    errors++; $display("FAIL out_data got %h expected %h", bus.out_data, e.data);
                end
                checks++;
                if ((exact && (cyc - e.cyc) != STAGES) || (cyc - e.cyc) < STAGES) begin
                    errors++; $display("FAIL latency got %0d expected %0d", cyc - e.cyc, STAGES);
                end
            end
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0 && exp_stall != (1 << CNT_W) - 1)
            exp_stall++;
        last_acc = bus.in_valid && bus.in_ready;
        if (flush) begin
            sb.delete();
        end else if (last_acc) begin
            e.data = bus.in_data + (tap_mode ? 64'(STAGES-1) : 64'd0);
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        bus.in_valid = 1'b0;
        if (!last_acc) begin
            checks++; errors++; $display("FAIL send_timeout got no accept expected accept of %h", d);
        end
    endtask

    task automatic drain();
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        n = 0;
        while ((sb.size() != 0 || occupancy != 0) && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0 || occupancy !== 0) begin
            errors++; $display("FAIL drain got %0d left expected 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (bus.out_valid !== 1'b0 || occupancy !== '0 || bus.out_data !== '0 ||
            stall_cnt !== '0 || tap_q !== '0) begin
            errors++;
            $display("FAIL %s got valid=%b occ=%0d data=%h stall=%0d expected all 0", tag,
                     bus.out_valid, occupancy, bus.out_data, stall_cnt);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int start;
        exact = 1'b1;
        bus.out_ready = 1'b1;
        start = emitted;
        for (int i = 1; i <= 10; i++) send(64'(i));
        drain();
        checks++;
        if (emitted - start != 10) begin
            errors++; $display("FAIL b2b_count got %0d expected 10", emitted - start);
        end
        exact = 1'b0;
    endtask

    task automatic test_fill_stall();
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send(64'h100 + 64'(i));
        #1;
        checks++;
        if (occupancy !== OCC_W'(STAGES) || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL full got occ=%0d rdy=%b expected occ=6 rdy=0", occupancy, bus.in_ready);
        end
        repeat (3) step();
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL full_passthru got rdy=%b expected 1", bus.in_ready);
        end
        drain();
    endtask

    task automatic test_collapse();
        bus.out_ready = 1'b0;
        send(64'hA1);
        repeat (8) step();
        send(64'hB2);
        repeat (6) step();
        #1;
        checks++;
        if (tap_q[4*DW +: DW] !== 64'hB2 || bus.out_data !== 64'hA1 || occupancy !== OCC_W'(2)) begin
            errors++;
            $display("FAIL collapse got r4=%h out=%h occ=%0d expected r4=b2 out=a1 occ=2",
                     tap_q[4*DW +: DW], bus.out_data, occupancy);
        end
        drain();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(64'h200 + 64'(i));
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (occupancy !== '0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL flush got occ=%0d valid=%b expected 0 0", occupancy, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_stall_saturate();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        sb.delete();
        exp_stall = 0;
        check_reset_outputs("stall_reset");
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        send(64'h33);
        repeat (STAGES + 20) step();
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++; $display("FAIL stall_sat got %0d expected 15", stall_cnt);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        tap_mode = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(64'h300 + 64'(i));
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid");
        sb.delete();
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b0;
        exact = 1'b1;
        bus.out_ready = 1'b1;
        send(64'h10);
        checks++;
        if (sb.size() != 1 || sb[0].data !== 64'h15) begin
            errors++; $display("FAIL plus1_model got %0d items expected one item of 15", sb.size());
        end
        drain();
        exact = 1'b0;
        tap_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_stall();
        test_collapse();
        test_flush();
        test_stall_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
